// File: rtl/dsm2_stim_echip65.sv
// dsm2_stim_echip65 - second-order delta-sigma modulator used as the BIST /
// loopback bitstream source for the CIC3 filter rows. A DC code is converted
// to a 1-bit stream whose ones-density encodes the code. Code changes take
// effect only on decimation-frame boundaries.
// Optional build macro: DSM_DITHER_EN adds a +/-1 LSB LFSR dither to the code.
module dsm2_stim_echip65 #(
    parameter int IN_WIDTH  = 16,
    parameter int INT_WIDTH = 20,
    parameter int DECIM     = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic signed [IN_WIDTH-1:0] code_in,
    input  logic                       code_valid,
    output logic                       code_ready,
    output logic                       out,
    output logic                       out_valid,
    output logic                       frame_strobe,
    output logic                       ovf,
    input  logic                       ovf_clr
);

    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    // Two guard bits cover integrator + code + 2*feedback without wrapping.
    localparam int SUM_W = INT_WIDTH + 2;

    localparam logic [CNT_W-1:0]          CNT_LAST  = CNT_W'(DECIM - 1);
    localparam logic signed [IN_WIDTH-1:0] CLAMP_POS = IN_WIDTH'(3 << (IN_WIDTH - 3));
    localparam logic signed [IN_WIDTH-1:0] CLAMP_NEG = -CLAMP_POS;
    localparam logic signed [SUM_W-1:0]    FS        = SUM_W'(64'sd1 << (IN_WIDTH - 1));
    localparam logic signed [SUM_W-1:0]    INT_MAX   = SUM_W'((64'sd1 << (INT_WIDTH - 1)) - 1);
    localparam logic signed [SUM_W-1:0]    INT_MIN   = -SUM_W'(64'sd1 << (INT_WIDTH - 1));

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic signed [INT_WIDTH-1:0] i1_q, i1_d, i2_q, i2_d;
    logic                        out_q, out_d;
    logic                        ovf_q, ovf_d;
    logic signed [IN_WIDTH-1:0]  active_q, active_d;
    logic signed [IN_WIDTH-1:0]  pend_code_q, pend_code_d;
    logic                        pending_q, pending_d;
    logic signed [IN_WIDTH-1:0]  code_clamped;

    logic                        running, last, apply;
    logic signed [SUM_W-1:0]     x, fb, sum1, sum2;
    logic                        hit1, hit2, sat_hit;

    // Clamp to the signed integrator range; the caller reports the clamp.
    function automatic logic signed [INT_WIDTH-1:0] sat(input logic signed [SUM_W-1:0] v);
        if (v > INT_MAX) return INT_MAX[INT_WIDTH-1:0];
        if (v < INT_MIN) return INT_MIN[INT_WIDTH-1:0];
        return v[INT_WIDTH-1:0];
    endfunction

    assign running = (state_q != IDLE);
    assign last    = running && (cnt_q == CNT_LAST);
    assign apply   = last && pending_q;

    // Limit incoming codes to +/-0.75 FS, inside the stable input range.
    always_comb begin
        code_clamped = code_in;
        if (code_in > CLAMP_POS)      code_clamped = CLAMP_POS;
        else if (code_in < CLAMP_NEG) code_clamped = CLAMP_NEG;
    end

    // Pending/active code handshake; a code taken on the boundary waits a frame.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        active_d    = active_q;
        pending_d   = pending_q;
        pend_code_d = pend_code_q;
        if (apply) begin
            active_d  = pend_code_q;
            pending_d = 1'b0;
        end
        if (code_valid && !pending_q) begin
            pend_code_d = code_clamped;
            pending_d   = 1'b1;
        end
    end

`ifdef DSM_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, advancing only while modulating.
    always_comb begin
        lfsr_d = lfsr_q;
        if (running) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // Dither state register, seeded so the sequence is repeatable after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end

    assign x = SUM_W'(active_q) + (lfsr_q[0] ? SUM_W'(1) : -SUM_W'(1));
`else
    assign x = SUM_W'(active_q);
`endif

    assign fb   = i2_q[INT_WIDTH-1] ? -FS : FS;
    assign sum1 = SUM_W'(i1_q) + x - fb;
    assign sum2 = SUM_W'(i2_q) + SUM_W'(i1_q) - (fb <<< 1);
    assign hit1 = (sum1 > INT_MAX) || (sum1 < INT_MIN);
    assign hit2 = (sum2 > INT_MAX) || (sum2 < INT_MIN);

    // Run/drain/idle sequencing; leaving the run states only on a frame boundary.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = last ? IDLE : DRAIN;
            DRAIN:   if (enable) state_d = RUN;
                     else if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Modulator datapath and frame counter; entering IDLE zeroes the loop.
    always_comb begin
        i1_d    = i1_q;
        i2_d    = i2_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        sat_hit = 1'b0;
        if (running) begin
            if (state_d == IDLE) begin
                i1_d  = '0;
                i2_d  = '0;
                out_d = 1'b0;
                cnt_d = '0;
            end else begin
                i1_d    = sat(sum1);
                i2_d    = sat(sum2);
                out_d   = ~i2_q[INT_WIDTH-1];
                cnt_d   = last ? '0 : cnt_q + 1'b1;
                sat_hit = hit1 | hit2;
            end
        end
        // A saturation in the same cycle as a clear keeps the flag set.
        ovf_d = sat_hit ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    // State registers; asynchronous reset returns every register to idle values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            i1_q        <= '0;
            i2_q        <= '0;
            out_q       <= 1'b0;
            ovf_q       <= 1'b0;
            active_q    <= '0;
            pend_code_q <= '0;
            pending_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            i1_q        <= i1_d;
            i2_q        <= i2_d;
            out_q       <= out_d;
            ovf_q       <= ovf_d;
            active_q    <= active_d;
            pend_code_q <= pend_code_d;
            pending_q   <= pending_d;
        end
    end

    assign code_ready   = !pending_q;
    assign out          = out_q;
    assign out_valid    = running;
    assign frame_strobe = last;
    assign ovf          = ovf_q;

endmodule

// File: doc/dsm2_stim_echip65.md
Name: dsm2_stim_echip65

Overview:
- Digital second-order delta-sigma modulator that generates the 1-bit modulator stream consumed by the CIC3 filter rows.
- Used as the on-chip BIST/loopback source: a programmed DC code is converted to a bitstream whose ones-density encodes the code.
- Code updates are aligned to decimation-frame boundaries, so the filters see clean steps.

Parameters:
- IN_WIDTH, 16, signed input code width; full scale FS = 2^(IN_WIDTH-1).
- INT_WIDTH, 20, signed integrator width (must be ≥ IN_WIDTH+3).
- DECIM, 64, frame length in clk cycles (decimation ratio of the downstream filter).

Ports:
- clk  input  1  common high-speed modulator clock.
- reset  input  1  asynchronous reset, active-high.
- enable  input  1  run request.
- code_in  input  IN_WIDTH  signed DC code.
- code_valid  input  1  code_in offered.
- code_ready  output  1  block can accept a code.
- out  output  1  modulator bitstream; fans out to the filter-row input.
- out_valid  output  1  out carries live modulator data.
- frame_strobe  output  1  one-cycle pulse on the last cycle of each frame.
- ovf  output  1  sticky integrator-saturation flag.
- ovf_clr  input  1  synchronous clear for ovf.

Behaviour:
- Reset values: out=0, out_valid=0, frame_strobe=0, ovf=0, code_ready=1, integrators i1=i2=0, frame counter=0, active code=0, pending=0, state=IDLE.
- Input handshake:
  - code_ready = !pending.
  - On code_valid&&code_ready, the code is clamped to ±(3·2^(IN_WIDTH-3)) and stored in the pending register; pending is set.
  - On a frame boundary (counter==DECIM-1) with pending set, the pending code is copied to the active code and pending is cleared.
  - A code accepted on the boundary cycle itself applies at the following boundary.
  - Handshake operates in all states.
- Modulator (RUN and DRAIN only), per clk:
  - fb = +FS if i2≥0, else −FS.
  - i1 <= sat(i1 + x − fb).
  - i2 <= sat(i2 + i1 − 2·fb), using the old i1.
  - x is the active code, sign-extended.
  - out <= (i2≥0), i.e. out lags the internal feedback decision by one cycle.
  - Resulting transfer: NTF=(1−z⁻¹)², STF=z⁻².
  - sat() clamps to the INT_WIDTH signed range. Any clamp event sets ovf.
  - ovf_clr clears ovf; if a set and a clear occur in the same cycle, set wins.
- Frame counter:
  - Counts 0..DECIM-1 and wraps in RUN and DRAIN.
  - frame_strobe=1 when counter==DECIM-1.
  - Held at 0 in IDLE.
- State machine:
  - IDLE -> RUN when enable=1. out_valid=1 from the first RUN cycle, with counter=0.
  - RUN -> DRAIN when enable=0 and counter!=DECIM-1.
  - RUN -> IDLE when enable=0 and counter==DECIM-1.
  - DRAIN runs to the frame boundary, then -> IDLE. If enable is reasserted during DRAIN, return to RUN without a gap.
  - On entering IDLE: i1, i2, counter, and out are cleared; out_valid=0. Active and pending codes are retained.
- Latency: from a boundary apply to the first affected out bit is 3 clk.
- Asynchronous reset mid-operation returns everything to the reset values immediately; no frame is completed.

Optional Feature:
- Macro: DSM_DITHER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advances every RUN/DRAIN cycle.
  - Its LSB adds +1 or −1 LSB to x, breaking idle tones.
  - The LFSR holds in IDLE.
- Undefined: no LFSR logic; x = active code exactly.

Test Plan:
- Reset/idle: assert reset mid-RUN -> all outputs return to reset values asynchronously. With enable=0 for 200 cycles -> out=0, out_valid=0, no frame_strobe.
- Zero code: enable with code 0 -> out_valid rises on the first RUN cycle; frame_strobe every 64 cycles; ones count per frame = 32±1 after the first frame.
- Half scale: code +16384 -> 48±2 ones per 64-cycle frame. Code −16384 -> 16±2 ones per frame. ovf remains 0.
- Handshake: accept code A mid-frame -> code_ready=0 until the boundary. A second code B offered meanwhile is not accepted. The density change appears only in the frame after the boundary.
- Clamp/overflow: code +32767 -> clamped to +24576, giving 56±2 ones per frame. Force i2 near the rail via a test hook -> ovf sets; ovf_clr clears it; a simultaneous set+clear leaves ovf=1.
- Drain: deassert enable at counter=10 -> DRAIN continues to counter 63, then IDLE with integrators zeroed. Reassert enable at counter 40 -> RUN continues seamlessly.
